// File: rtl/wavegen_cfg_master.sv
// wavegen_cfg_master: turns single register read/write commands into
// AXI4-Lite master transactions, one at a time, and hands back the
// captured response together with a saturating error counter.
module wavegen_cfg_master #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  // command side
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response side
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [7:0]                        err_count,
  // AXI4-Lite master
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int SW = C_M00_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic            bready_q, bready_d;
  logic            rready_q, rready_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            capture;
  logic [1:0]      cap_resp;

  // Command acceptance is only possible in IDLE and never while reset is held.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;

  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = wstrb_q;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_bready  = bready_q;
  assign m00_axi_rready  = rready_q;

  // Next-state, next AXI handshake outputs and response capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = 1'b0;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_count_d = err_count_q;
    capture     = 1'b0;
    cap_resp    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // Registers are word aligned: the byte offset is dropped.
          addr_d  = cmd_addr & ~AW'(3);
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; a dropped valid marks its channel done.
        if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m00_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m00_axi_bvalid && bready_q) begin
          capture     = 1'b1;
          cap_resp    = m00_axi_bresp;
          rsp_rdata_d = '0;
          rsp_resp_d  = m00_axi_bresp;
          state_d     = RSP;
        end else begin
          bready_d = 1'b1;
        end
      end
      RD_REQ: begin
        if (arvalid_q && m00_axi_arready) begin
          state_d  = RD_DATA;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (m00_axi_rvalid && rready_q) begin
          capture     = 1'b1;
          cap_resp    = m00_axi_rresp;
          rsp_rdata_d = m00_axi_rdata;
          rsp_resp_d  = m00_axi_rresp;
          state_d     = RSP;
        end else begin
          rready_d = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture && (cap_resp != 2'b00) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State and all registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_wavegen_cfg_master.sv
// Testbench for wavegen_cfg_master: a task-driven AXI4-Lite slave with
// configurable channel delays and a response/error-count reference model.
module tb_wavegen_cfg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_count;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  wavegen_cfg_master #(.C_M00_AXI_DATA_WIDTH(32), .C_M00_AXI_ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err_count(err_count),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  // One full command: issue it, play the slave with the given delays, collect the response.
  task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int aw_dly, input int w_dly,
                         input int b_dly, input int ar_dly, input int r_dly,
                         input logic [1:0] resp, input logic [31:0] rd, input int hold,
                         output logic [31:0] o_rdata, output logic [1:0] o_resp,
                         output logic [7:0] o_err);
    logic [5:0] ea;
    int n;
    ea = {addr[5:2], 2'b00};
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready got %b want 0", cmd_ready); end
    if (wr) begin
      fork
        begin : aw_ch
          int k;
          k = 0;
          while (awvalid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
          checks++;
          if (awvalid !== 1'b1 || awaddr !== ea || awprot !== 3'b000) begin
            errors++; $display("FAIL aw_start awvalid=%b awaddr=%h prot=%b want 1 %h 000", awvalid, awaddr, awprot, ea);
          end
          repeat (aw_dly) begin
            @(negedge clk);
            checks++;
            if (awvalid !== 1'b1 || awaddr !== ea || bready !== 1'b0) begin
              errors++; $display("FAIL aw_hold awvalid=%b awaddr=%h bready=%b want 1 %h 0", awvalid, awaddr, bready, ea);
            end
          end
          awready = 1'b1;
          @(negedge clk);
          awready = 1'b0;
          checks++;
          if (awvalid !== 1'b0) begin errors++; $display("FAIL aw_drop awvalid=%b want 0", awvalid); end
        end
        begin : w_ch
          int k;
          k = 0;
          while (wvalid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
          checks++;
          if (wvalid !== 1'b1 || wdata !== wd || wstrb !== ws) begin
            errors++; $display("FAIL w_start wvalid=%b wdata=%h wstrb=%h want 1 %h %h", wvalid, wdata, wstrb, wd, ws);
          end
          repeat (w_dly) begin
            @(negedge clk);
            checks++;
            if (wvalid !== 1'b1 || wdata !== wd || wstrb !== ws || bready !== 1'b0) begin
              errors++; $display("FAIL w_hold wvalid=%b wdata=%h wstrb=%h bready=%b", wvalid, wdata, wstrb, bready);
            end
          end
          wready = 1'b1;
          @(negedge clk);
          wready = 1'b0;
          checks++;
          if (wvalid !== 1'b0) begin errors++; $display("FAIL w_drop wvalid=%b want 0", wvalid); end
        end
      join
      repeat (b_dly) begin
        checks++;
        if (bready !== 1'b1) begin errors++; $display("FAIL b_wait bready=%b want 1", bready); end
        @(negedge clk);
      end
      checks++;
      if (bready !== 1'b1) begin errors++; $display("FAIL b_ready bready=%b want 1", bready); end
      bvalid = 1'b1; bresp = resp;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'b00;
      checks++;
      if (bready !== 1'b0) begin errors++; $display("FAIL b_done bready=%b want 0", bready); end
    end else begin
      n = 0;
      while (arvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (arvalid !== 1'b1 || araddr !== ea || arprot !== 3'b000 || rready !== 1'b0) begin
        errors++; $display("FAIL ar_start arvalid=%b araddr=%h rready=%b want 1 %h 0", arvalid, araddr, rready, ea);
      end
      repeat (ar_dly) begin
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || araddr !== ea || rready !== 1'b0) begin
          errors++; $display("FAIL ar_hold arvalid=%b araddr=%h rready=%b", arvalid, araddr, rready);
        end
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b1) begin
        errors++; $display("FAIL ar_done arvalid=%b rready=%b want 0 1", arvalid, rready);
      end
      // A stray error B beat during the read must be ignored.
      for (int i = 0; i < r_dly; i++) begin
        if (i == 0) begin bvalid = 1'b1; bresp = 2'b11; end
        else begin bvalid = 1'b0; bresp = 2'b00; end
        @(negedge clk);
        checks++;
        if (rready !== 1'b1 || rsp_valid !== 1'b0) begin
          errors++; $display("FAIL r_wait rready=%b rsp_valid=%b want 1 0", rready, rsp_valid);
        end
      end
      bvalid = 1'b0; bresp = 2'b00;
      rvalid = 1'b1; rdata = rd; rresp = resp;
      @(negedge clk);
      rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      checks++;
      if (rready !== 1'b0) begin errors++; $display("FAIL r_done rready=%b want 0", rready); end
    end
    if (resp != 2'b00 && exp_err < 255) exp_err++;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout rsp_valid=%b want 1", rsp_valid); end
    o_rdata = rsp_rdata; o_resp = rsp_resp; o_err = err_count;
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata || rsp_resp !== o_resp || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL rsp_hold valid=%b rdata=%h resp=%b cmd_ready=%b", rsp_valid, rsp_rdata, rsp_resp, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_done rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready} !== 7'b0 ||
        rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || err_count !== 8'h00 ||
        awaddr !== 6'h0 || araddr !== 6'h0 || wdata !== 32'h0) begin
      errors++; $display("FAIL reset_state ctl=%b rdata=%h resp=%b err=%0d awaddr=%h wdata=%h want all zero",
                         {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, rsp_rdata, rsp_resp, err_count, awaddr, wdata);
    end
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_write_same_cycle();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    run_txn(1'b1, 6'h06, 32'h0000C350, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, od, orr, oe);
    checks++;
    if (od !== 32'h0 || orr !== 2'b00 || oe !== 8'd0) begin
      errors++; $display("FAIL write_same_cycle rdata=%h resp=%b err=%0d want 0 00 0", od, orr, oe);
    end
  endtask

  task automatic test_write_aw_first();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    run_txn(1'b1, 6'h10, 32'h12345678, 4'h5, 0, 3, 2, 0, 0, 2'b00, 32'h0, 1, od, orr, oe);
    checks++;
    if (od !== 32'h0 || orr !== 2'b00 || oe !== 8'(exp_err)) begin
      errors++; $display("FAIL write_aw_first rdata=%h resp=%b err=%0d want 0 00 %0d", od, orr, oe, exp_err);
    end
  endtask

  task automatic test_read_delay();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    run_txn(1'b0, 6'h08, 32'h0, 4'h0, 0, 0, 0, 1, 4, 2'b00, 32'hDEADBEEF, 0, od, orr, oe);
    checks++;
    if (od !== 32'hDEADBEEF || orr !== 2'b00 || oe !== 8'(exp_err)) begin
      errors++; $display("FAIL read_delay rdata=%h resp=%b err=%0d want deadbeef 00 %0d", od, orr, oe, exp_err);
    end
  endtask

  task automatic test_read_err_hold();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    run_txn(1'b0, 6'h2C, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b10, 32'hA5A55A5A, 5, od, orr, oe);
    checks++;
    if (od !== 32'hA5A55A5A || orr !== 2'b10 || oe !== 8'd1) begin
      errors++; $display("FAIL read_err_hold rdata=%h resp=%b err=%0d want a5a55a5a 10 1", od, orr, oe);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h14; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (awvalid !== 1'b1) begin errors++; $display("FAIL mid_pre awvalid=%b want 1", awvalid); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0 ||
        err_count !== 8'd0 || awaddr !== 6'h0) begin
      errors++; $display("FAIL mid_reset ctl=%b err=%0d awaddr=%h want all zero",
                         {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, err_count, awaddr);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || awvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release cmd_ready=%b rsp_valid=%b awvalid=%b want 1 0 0", cmd_ready, rsp_valid, awvalid);
    end
    run_txn(1'b0, 6'h04, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BADC0DE, 0, od, orr, oe);
    checks++;
    if (od !== 32'h0BADC0DE || orr !== 2'b00 || oe !== 8'd0) begin
      errors++; $display("FAIL mid_recover rdata=%h resp=%b err=%0d want 0badc0de 00 0", od, orr, oe);
    end
  endtask

  task automatic test_random();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [5:0]  a;
      logic [31:0] d, rd;
      logic [3:0]  s;
      logic [1:0]  rs;
      wr = 1'($urandom_range(0, 1));
      a  = 6'($urandom_range(0, 63));
      d  = $urandom;
      rd = $urandom;
      s  = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      run_txn(wr, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), rs, rd, $urandom_range(0, 3), od, orr, oe);
      checks++;
      if (od !== (wr ? 32'h0 : rd) || orr !== rs || oe !== 8'(exp_err)) begin
        errors++; $display("FAIL random_%0d rdata=%h resp=%b err=%0d want %h %b %0d",
                           i, od, orr, oe, (wr ? 32'h0 : rd), rs, exp_err);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] od; logic [1:0] orr; logic [7:0] oe;
    for (int i = 0; i < 300; i++) begin
      run_txn(i[0], 6'(i), 32'(i), 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'(i * 3), 0, od, orr, oe);
    end
    checks++;
    if (oe !== 8'(exp_err) || exp_err != 255) begin
      errors++; $display("FAIL saturation err=%0d want %0d (model), 255", oe, exp_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_aw_first();
    test_read_delay();
    test_read_err_hold();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavegen_cfg_master.md
WAVEGEN_CFG_MASTER -- requirements
Module: wavegen_cfg_master

Interface
REQ-001 SHALL have parameter C_M00_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_M00_AXI_ADDR_WIDTH, default 6, AXI4-Lite byte-address width.
REQ-003 SHALL have one clock and an asynchronous active-high reset, as the following two port lines state.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = register write, 0 = register read.
REQ-009 SHALL have port cmd_addr  input  C_M00_AXI_ADDR_WIDTH  register byte address.
REQ-010 SHALL have port cmd_wdata  input  32  write data.
REQ-011 SHALL have port cmd_wstrb  input  4  write byte strobes.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed.
REQ-014 SHALL have port rsp_rdata  output  32  read data; 0 for writes.
REQ-015 SHALL have port rsp_resp  output  2  captured BRESP/RRESP.
REQ-016 SHALL have port err_count  output  8  saturating count of non-OKAY responses.
REQ-017 SHALL have ports m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready, with standard AXI4-Lite master directions and widths.

Function
REQ-018 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-019 SHALL drive cmd_ready high only in IDLE, combinationally from state.
REQ-020 SHALL, on cmd_valid&&cmd_ready, register addr (bits [1:0] forced 0), data, strobes, and move to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-021 SHALL drive awvalid and wvalid high from the first WR_REQ cycle (one cycle after acceptance), all AXI outputs registered.
REQ-022 SHALL deassert awvalid the cycle after awready is sampled high, and wvalid independently after wready; each SHALL remain stable until its handshake.
REQ-023 SHALL enter WR_RESP once both AW and W handshakes have completed, including both in the same cycle.
REQ-024 SHALL assert bready only in WR_RESP; on bvalid&&bready capture bresp, set rsp_rdata=0, enter RSP.
REQ-025 SHALL assert arvalid in RD_REQ, held until arready; then enter RD_DATA.
REQ-026 SHALL assert rready only in RD_DATA; on rvalid&&rready capture rdata/rresp, enter RSP.
REQ-027 SHALL hold rsp_valid high in RSP with stable rsp_rdata/rsp_resp until rsp_ready, then return to IDLE next cycle.
REQ-028 SHALL tie awprot and arprot to 3'b000.
REQ-029 SHALL increment err_count by one per captured response with resp != 2'b00, saturating at 255.
REQ-030 SHALL have at most one transaction outstanding; a new command is not accepted before rsp handshake.
REQ-031 SHALL ignore bvalid/rvalid arriving in any state other than WR_RESP/RD_DATA respectively.

Reset
REQ-032 SHALL, while rst is high, force state IDLE and all valid/ready outputs low, rsp_rdata=0, rsp_resp=0, err_count=0, addresses/data 0, asynchronously.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction with no response produced; err_count cleared.
REQ-034 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-035 Write addr 0x06, data 0x0000C350, strb 0xF, slave accepts AW/W same cycle, BRESP=00 -> awaddr=0x04, one response with rsp_resp=00, rsp_rdata=0, err_count=0.
REQ-036 Write with awready 3 cycles before wready -> awvalid drops after AW handshake, wvalid held stable until wready; single B accepted.
REQ-037 Read addr 0x08, slave returns rdata 0xDEADBEEF after 4-cycle rvalid delay -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rready high only in RD_DATA.
REQ-038 Read returning RRESP=10, rsp_ready held low 5 cycles -> rsp_valid stays high, outputs stable, cmd_ready low, err_count=1.
REQ-039 300 back-to-back commands all SLVERR -> err_count saturates at 255.
REQ-040 rst asserted while awvalid high -> all AXI valids low immediately, state IDLE, no rsp_valid, cmd_ready high after release.
